stopwatch_countdown: RTL
========================

# stopwatch_countdown

Down-counting companion to the stopwatch counter: loads a preset value, decrements it under start/stop control, and signals expiry when it reaches zero. Sits beside the up-counting stopwatch in the timer datapath, fed by the same start/stop control strobes. It drives the display count and raises an expiry pulse for alarm/sequencing logic. A built-in prescaler sets how many clocks elapse per decrement.

## Interface
- DATA_WIDTH, 16: width of count, load_value and reload register
- TICK_DIV, 1: clocks per decrement while running; legal range 1..2^16
- clk  input  1  rising-edge clock
- reset_n  input  1  reset; asynchronous and active-low
- load  input  1  synchronous strobe; captures load_value
- load_value  input  DATA_WIDTH  preset; sampled only when load=1
- start  input  1  level or strobe; begins or resumes countdown
- stop  input  1  level or strobe; pauses countdown
- count  output  DATA_WIDTH  current remaining value, registered
- running  output  1  high while in RUN
- done  output  1  high while in DONE
- expired  output  1  one-cycle pulse, coincident with count becoming 0 via decrement

## Operation
- States: IDLE, RUN, PAUSE, DONE. Reset values: state IDLE, count 0, prescaler 0, reload register 0, running 0, done 0, expired 0.
- Per-cycle priority: load > stop > start > tick.
- load (any state): count <= load_value, reload <= load_value, prescaler <= 0, state <= IDLE. load_value 0 is legal; the block stays in IDLE with count 0.
- IDLE/PAUSE + start + count != 0: state <= RUN. From IDLE, prescaler <= 0; from PAUSE, prescaler keeps its value.
- IDLE/PAUSE + start + count == 0: ignored; no state change.
- RUN + stop: state <= PAUSE; count and prescaler hold.
- RUN, no stop:
  - prescaler increments each cycle; tick when prescaler == TICK_DIV-1, then prescaler <= 0.
  - On tick with count > 1: count <= count-1.
  - On tick with count == 1: count <= 0, expired <= 1 for one cycle, state <= DONE.
- DONE: count holds 0; start and stop are ignored; only load or reset exits.
- Simultaneous start and stop: stop wins.
- Simultaneous load and any other input: load wins.
- Count never wraps below 0. Arithmetic is unsigned at DATA_WIDTH.
- Asynchronous reset mid-count returns all state to reset values immediately.

## Timing
- All outputs are registered. running and done decode the state register.
- start sampled at edge E (IDLE): running=1 after E. With TICK_DIV=1, the first decrement is visible after E+1. In general, the first decrement is TICK_DIV cycles after entering RUN from IDLE.
- stop sampled at edge E: no decrement at E; running=0 after E.
- Resume from PAUSE: the remaining prescaler phase is preserved, so total RUN cycles per decrement are exactly TICK_DIV across pauses.
- expired rises at the same edge count goes 1→0 and falls the next edge.
- done rises at that same edge.
- load takes effect at the sampling edge. A load issued during an expiry edge wins, and expired is not raised.

## Configuration
- STOPWATCH_COUNTDOWN_AUTO_RELOAD_EN defined: on the 1→0 tick, count <= reload and state stays RUN. expired still pulses. DONE is unreachable, so done stays 0. If reload == 0, the block goes to DONE as in the non-reload case.
- Undefined: the block behaves as described above, with DONE terminal until load or reset. No reload register is needed beyond what load uses, and synthesis may trim it.

## Structure
- Shared package stopwatch_pkg holds the state enum typedef (IDLE, RUN, PAUSE, DONE) and the default DATA_WIDTH constant shared with the up-counter.
- One sub-module: stopwatch_tick_prescaler (enable, clear, TICK_DIV parameter → tick pulse). It is reused by the up-counter for rate scaling.
- The top holds the FSM, count register, reload register and output registers.

## Test plan
- Reset then load 5, start, TICK_DIV=1 → count 5,4,3,2,1,0 on consecutive cycles after the start edge. expired is high exactly at count 0. done=1 and running=0 thereafter.
- TICK_DIV=4, load 3, start, stop after 6 RUN cycles, wait 10, start → count reaches 0 exactly 12 RUN cycles after the first start. The pause contributes no ticks.
- Load 0 then start → stays IDLE, count 0, expired never asserts. start and stop asserted together in IDLE with count 7 → stays IDLE.
- In DONE, assert start → no change. Then load 2 → IDLE, count 2, done=0.
- Drop reset_n asynchronously mid-RUN (count 9) → count 0, running 0 immediately, without waiting for a clk edge.
- With STOPWATCH_COUNTDOWN_AUTO_RELOAD_EN, load 3, start → sequence 3,2,1,0→3,2,… with one expired pulse per period; done never asserts.

Source files
------------

// File: rtl/stopwatch_pkg.sv
// rtl/stopwatch_pkg.sv - shared types and constants for the stopwatch timer datapath
package stopwatch_pkg;

  localparam int SW_DATA_WIDTH = 16;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    PAUSE = 2'd2,
    DONE  = 2'd3
  } sw_state_e;

endpackage

// File: rtl/stopwatch_tick_prescaler.sv
// rtl/stopwatch_tick_prescaler.sv - rate divider: one tick per TICK_DIV enabled clocks
module stopwatch_tick_prescaler #(
  parameter int TICK_DIV = 1
) (
  input  logic clk,
  input  logic reset_n,
  input  logic i_enable,
  input  logic i_clear,
  output logic o_tick
);

  localparam int CW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(TICK_DIV - 1);

  logic [CW-1:0] r_phase;

  // Phase only advances while enabled, so a paused count keeps its partial period.
  assign o_tick = i_enable && (r_phase == LAST);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_phase <= '0;
    end else if (i_clear || o_tick) begin
      r_phase <= '0;
    end else if (i_enable) begin
      r_phase <= r_phase + CW'(1);
    end
  end

endmodule

// File: rtl/stopwatch_countdown.sv
// rtl/stopwatch_countdown.sv - preset down-counter with start/stop control and expiry pulse
// Optional STOPWATCH_COUNTDOWN_AUTO_RELOAD_EN: reload the preset on expiry instead of stopping.
module stopwatch_countdown
  import stopwatch_pkg::*;
#(
  parameter int DATA_WIDTH = SW_DATA_WIDTH,
  parameter int TICK_DIV   = 1
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  load,
  input  logic [DATA_WIDTH-1:0] load_value,
  input  logic                  start,
  input  logic                  stop,
  output logic [DATA_WIDTH-1:0] count,
  output logic                  running,
  output logic                  done,
  output logic                  expired
);

  sw_state_e             r_state, w_state_nxt;
  logic [DATA_WIDTH-1:0] r_count, w_count_nxt;
  logic                  r_expired, w_expired_nxt;
  logic                  w_tick, w_psc_en, w_psc_clr, w_count_nz;
`ifdef STOPWATCH_COUNTDOWN_AUTO_RELOAD_EN
  logic [DATA_WIDTH-1:0] r_reload;
`endif

  assign w_count_nz = (r_count != '0);
  assign w_psc_en   = (r_state == RUN) && !stop && !load;
  assign w_psc_clr  = load || ((r_state == IDLE) && start && !stop && w_count_nz);

  stopwatch_tick_prescaler #(
    .TICK_DIV (TICK_DIV)
  ) u_prescaler (
    .clk      (clk),
    .reset_n  (reset_n),
    .i_enable (w_psc_en),
    .i_clear  (w_psc_clr),
    .o_tick   (w_tick)
  );

  always_comb begin
    w_state_nxt   = r_state;
    w_count_nxt   = r_count;
    w_expired_nxt = 1'b0;
    if (load) begin
      w_state_nxt = IDLE;
      w_count_nxt = load_value;
    end else begin
      case (r_state)
        IDLE, PAUSE: begin
          if (start && !stop && w_count_nz) begin
            w_state_nxt = RUN;
          end
        end
        RUN: begin
          if (stop) begin
            w_state_nxt = PAUSE;
          end else if (w_tick) begin
            if (r_count > DATA_WIDTH'(1)) begin
              w_count_nxt = r_count - DATA_WIDTH'(1);
            end else begin
              w_expired_nxt = 1'b1;
`ifdef STOPWATCH_COUNTDOWN_AUTO_RELOAD_EN
              if (r_reload != '0) begin
                w_count_nxt = r_reload;
              end else begin
                w_count_nxt = '0;
                w_state_nxt = DONE;
              end
`else
              w_count_nxt = '0;
              w_state_nxt = DONE;
`endif
            end
          end
        end
        DONE: begin
          w_state_nxt = DONE;
        end
        default: begin
          w_state_nxt = IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state   <= IDLE;
      r_count   <= '0;
      r_expired <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_count   <= w_count_nxt;
      r_expired <= w_expired_nxt;
    end
  end

`ifdef STOPWATCH_COUNTDOWN_AUTO_RELOAD_EN
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_reload <= '0;
    end else if (load) begin
      r_reload <= load_value;
    end
  end
`endif

  assign count   = r_count;
  assign running = (r_state == RUN);
  assign done    = (r_state == DONE);
  assign expired = r_expired;

endmodule
